// File: rtl/mux16_rr_arbiter_if.sv
// Bus bundle for the 16-channel round-robin arbiter with its shared 16:1 data mux.
interface mux16_rr_arbiter_if;
  logic [15:0] req;
  logic        rel;
  logic [15:0] din;
  logic [3:0]  sel;
  logic [15:0] grant;
  logic        gnt_valid;
  logic        out;

  modport master (
    output req, rel, din,
    input  sel, grant, gnt_valid, out
  );

  modport slave (
    input  req, rel, din,
    output sel, grant, gnt_valid, out
  );
endinterface

// File: rtl/mux16_rr_arbiter.sv
// Round-robin arbiter for 16 requesters driving the select of a shared 16:1 mux,
// with a bounded hold time and a one-cycle break-before-make gap between owners.
module mux16_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input logic             clk,
  input logic             rst_n,
  mux16_rr_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t      state;
  state_t      state_next;
  logic [3:0]  ptr;
  logic [3:0]  ptr_next;
  logic [3:0]  sel_q;
  logic [3:0]  sel_next;
  logic [15:0] grant_q;
  logic [15:0] grant_next;
  logic        valid_q;
  logic [7:0]  hold_cnt;
  logic [7:0]  hold_next;

  logic [3:0]  win;
  logic        win_found;
  logic [3:0]  scan_idx;
  logic        owner_done;

  // Scan upward from ptr with 4-bit wrap; the first set request wins.
  always_comb begin
    win       = '0;
    win_found = 1'b0;
    scan_idx  = '0;
    for (int i = 0; i < 16; i++) begin
      scan_idx = ptr + 4'(i);
      if (!win_found && bus.req[scan_idx]) begin
        win       = scan_idx;
        win_found = 1'b1;
      end
    end
  end

  assign owner_done = bus.rel || !bus.req[sel_q] || (hold_cnt == HOLD_LAST);

  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    sel_next   = sel_q;
    grant_next = grant_q;
    hold_next  = hold_cnt;

    unique case (state)
      IDLE, GAP: begin
        if (win_found) begin
          state_next = GRANT;
          sel_next   = win;
          grant_next = 16'(1) << win;
          hold_next  = '0;
        end else begin
          state_next = IDLE;
          grant_next = '0;
        end
      end

      GRANT: begin
        // All exit causes collapse into a single transition and pointer step.
        if (owner_done) begin
          state_next = GAP;
          ptr_next   = sel_q + 4'd1;
          grant_next = '0;
        end else begin
          hold_next = hold_cnt + 8'd1;
        end
      end

      default: begin
        state_next = IDLE;
        grant_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      sel_q    <= '0;
      grant_q  <= '0;
      valid_q  <= 1'b0;
      hold_cnt <= '0;
    end else begin
      state    <= state_next;
      ptr      <= ptr_next;
      sel_q    <= sel_next;
      grant_q  <= grant_next;
      valid_q  <= |grant_next;
      hold_cnt <= hold_next;
    end
  end

  assign bus.sel       = sel_q;
  assign bus.grant     = grant_q;
  assign bus.gnt_valid = valid_q;
  assign bus.out       = valid_q ? bus.din[sel_q] : 1'b0;

endmodule

// File: doc/mux16_rr_arbiter.md
MUX16_RR_ARBITER -- requirements
Module: mux16_rr_arbiter

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 8, meaning the maximum number of consecutive cycles one requester may hold a grant (legal range 1..255).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset, synchronous and active-low.
REQ-004 SHALL have port req, input, 16, per-channel request; bit i requests ownership of mux input i.
REQ-005 SHALL have port rel, input, 1, current owner done; sampled only in GRANT.
REQ-006 SHALL have port din, input, 16, data bits of the shared 16:1 mux.
REQ-007 SHALL have port sel, output, 4, registered mux select and index of the current or most recent owner.
REQ-008 SHALL have port grant, output, 16, registered one-hot grant; all zero when no owner.
REQ-009 SHALL have port gnt_valid, output, 1, registered; high exactly when grant is non-zero.
REQ-010 SHALL have port out, output, 1, combinational din[sel] when gnt_valid is high, else 0.

Function
REQ-011 SHALL implement an FSM with states IDLE, GRANT and GAP.
REQ-012 SHALL keep a 4-bit round-robin pointer ptr; arbitration scans req from bit ptr upward, wrapping 15->0, and picks the first set bit.
REQ-013 In IDLE with req != 0 at a rising edge, SHALL enter GRANT on that edge, with sel = winner, grant = 1<<winner, gnt_valid = 1 (one-cycle request-to-grant latency).
REQ-014 In IDLE with req == 0, SHALL remain in IDLE with grant = 0 and sel unchanged.
REQ-015 SHALL hold an 8-bit hold counter, cleared on entering GRANT and incremented each cycle in GRANT.
REQ-016 SHALL leave GRANT for GAP at the first edge where rel = 1, req[sel] = 0, or the hold counter equals MAX_HOLD-1; the owner therefore holds for at most MAX_HOLD cycles.
REQ-017 On the GRANT->GAP edge, SHALL set ptr = sel+1 mod 16 (15 wraps to 0) and clear grant and gnt_valid.
REQ-018 GAP SHALL last exactly one cycle with grant = 0 (break-before-make); at the next edge, it SHALL arbitrate as in IDLE: enter GRANT if req != 0, otherwise enter IDLE.
REQ-019 SHALL keep sel constant while in GRANT; changes to req bits other than req[sel] SHALL NOT affect the current grant.
REQ-020 If multiple exit conditions occur on one edge, SHALL perform one GRANT->GAP transition and one ptr update.
REQ-021 The just-released requester SHALL be eligible again only after all other requesters that are set are served, as ptr ordering gives.
REQ-022 If the only requester is the previous owner, SHALL grant it again after the GAP cycle.
REQ-023 grant SHALL never have more than one bit set, and gnt_valid SHALL equal the OR-reduction of grant in every cycle.

Reset
REQ-024 With rst_n = 0 at a rising edge, SHALL set state = IDLE, ptr = 0, sel = 0, grant = 0, gnt_valid = 0 and hold counter = 0, regardless of the current state.
REQ-025 Reset during GRANT SHALL drop the grant at that edge; after the first edge with rst_n = 1, arbitration SHALL restart from ptr = 0.
REQ-026 out SHALL be 0 while gnt_valid = 0, including during reset.

Verification
REQ-027 Reset then req = 16'h0001 -> one edge later grant = 16'h0001, sel = 0, gnt_valid = 1; with din = 16'h3f0a, out = 0.
REQ-028 req = 16'h8003 held, rel pulsed each grant -> grant order 0, 1, 15, 0, with one zero-grant GAP cycle between grants.
REQ-029 MAX_HOLD = 8, req = 16'h0006, rel never asserted -> channel 1 holds for exactly 8 cycles, GAP, then channel 2 granted; with din = 16'h3f0a, out = 1 then 0.
REQ-030 Owner drops req[sel] mid-grant while req[7] is set -> GAP on the next edge, then grant = 16'h0080.
REQ-031 Reset asserted for one cycle during GRANT of channel 9 with req = 16'h0201 -> grant = 0 at that edge, then grant = 16'h0001 (ptr back to 0).
REQ-032 Randomised req/rel for 10k cycles -> grant is always one-hot or zero, no requester waits more than 15*(MAX_HOLD+1) cycles, and out == din[sel] whenever gnt_valid = 1.
